// File: rtl/ray_pixel_scheduler_pkg.sv
// ray_pixel_scheduler_pkg
//   Shared fixed-point / display constants for the ray pixel scheduler.
//   fp_t is signed Q3.12 (16 bits), enough for the normalised screen range
//   of small-aspect displays (|x| <= W/H, |y| <= 1).
//   Display macros (DISPLAY_WIDTH, DISPLAY_HEIGHT, H_BITS, V_BITS) may be
//   supplied on the command line; the fallbacks below describe a 4x2 panel.

`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 4
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 2
`endif
`ifndef H_BITS
`define H_BITS 4
`endif
`ifndef V_BITS
`define V_BITS 4
`endif

package ray_pixel_scheduler_pkg;

  localparam int DISP_W  = `DISPLAY_WIDTH;
  localparam int DISP_H  = `DISPLAY_HEIGHT;
  localparam int FP_W    = 16;
  localparam int FP_FRAC = 12;

  typedef logic signed [FP_W-1:0] fp_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  // Wrapping fixed-point add; the only arithmetic used on x/y.
  function automatic fp_t fp_add(input fp_t a, input fp_t b);
    return a + b;
  endfunction

  // num/den in fixed point, elaboration-time only.
  function automatic fp_t fp_from_ratio(input int num, input int den);
    return fp_t'((num * (1 << FP_FRAC)) / den);
  endfunction

  function automatic fp_t fp_px_start(input int w, input int h);
    return fp_from_ratio(-w, h);
  endfunction

  function automatic fp_t fp_pixel_step(input int h);
    return fp_from_ratio(2, h);
  endfunction

  localparam fp_t FP_PX_START   = fp_px_start(DISP_W, DISP_H);  // -W/H
  localparam fp_t FP_PY_START   = fp_from_ratio(-1, 1);          // -1.0
  localparam fp_t FP_PIXEL_STEP = fp_pixel_step(DISP_H);         // 2/H

endpackage

// File: rtl/ray_pixel_scheduler.sv
// ray_pixel_scheduler
//   Walks every pixel of a frame in raster order and hands one descriptor
//   (h, v, normalised x, normalised y) per transfer to the ray generator
//   over a valid/ready handshake. x/y are accumulated, never multiplied.
//   Optional feature: RAY_SCHED_INTERLACE_EN -- alternate fields per frame
//   (even rows first after reset, then odd rows, ...).
// Ports
//   clk_in, rst_n_in (async, active low)
//   start_in        : frame start request (ignored while a frame runs)
//   ready_in        : downstream ready
//   valid_out       : descriptor valid
//   hcount_out      : pixel column     vcount_out    : pixel row
//   hcount_fp_out   : (2h - W)/H       vcount_fp_out : (2v - H)/H
//   busy_out        : frame in progress
//   frame_done_out  : one-cycle pulse after the last pixel transfers

`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 4
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 2
`endif
`ifndef H_BITS
`define H_BITS 4
`endif
`ifndef V_BITS
`define V_BITS 4
`endif

module ray_pixel_scheduler
  import ray_pixel_scheduler_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int H_BITS         = `H_BITS,
  parameter int V_BITS         = `V_BITS
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [H_BITS-1:0] hcount_out,
  output logic [V_BITS-1:0] vcount_out,
  output logic [FP_W-1:0]   hcount_fp_out,
  output logic [FP_W-1:0]   vcount_fp_out,
  output logic              busy_out,
  output logic              frame_done_out
);

  // Constants derived from this instance's geometry via the package helpers,
  // so an overridden W/H stays consistent.
  localparam fp_t PX_START = fp_px_start(DISPLAY_WIDTH, DISPLAY_HEIGHT);
  localparam fp_t PY_START = fp_from_ratio(-1, 1);
  localparam fp_t PX_STEP  = fp_pixel_step(DISPLAY_HEIGHT);

  localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);

`ifdef RAY_SCHED_INTERLACE_EN
  localparam int  V_STEP = 2;
  localparam fp_t Y_STEP = fp_add(PX_STEP, PX_STEP);
  logic field_odd;
`else
  localparam int  V_STEP = 1;
  localparam fp_t Y_STEP = PX_STEP;
  localparam logic field_odd = 1'b0;
`endif

  state_e state_q;

  logic [V_BITS-1:0] v_start;
  fp_t               y_start;
  logic              col_last;
  logic              row_last;
  logic              xfer;

  always_comb begin
    v_start  = V_BITS'(field_odd);
    y_start  = field_odd ? fp_add(PY_START, PX_STEP) : PY_START;
    col_last = (hcount_out == H_LAST);
    // Last row of the current field: stepping once more leaves the frame.
    row_last = (int'(vcount_out) + V_STEP >= DISPLAY_HEIGHT);
    xfer     = valid_out & ready_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= S_IDLE;
      valid_out      <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      hcount_fp_out  <= '0;
      vcount_fp_out  <= '0;
`ifdef RAY_SCHED_INTERLACE_EN
      field_odd      <= 1'b0;
`endif
    end else begin
      frame_done_out <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Also covers the frame_done cycle, so back-to-back starts work.
          if (start_in) begin
            state_q       <= S_ISSUE;
            valid_out     <= 1'b1;
            busy_out      <= 1'b1;
            hcount_out    <= '0;
            vcount_out    <= v_start;
            hcount_fp_out <= PX_START;
            vcount_fp_out <= y_start;
          end
        end
        S_ISSUE: begin
          if (xfer) begin
            if (!col_last) begin
              hcount_out    <= hcount_out + H_BITS'(1);
              hcount_fp_out <= fp_add(fp_t'(hcount_fp_out), PX_STEP);
            end else if (!row_last) begin
              hcount_out    <= '0;
              hcount_fp_out <= PX_START;
              vcount_out    <= vcount_out + V_BITS'(V_STEP);
              vcount_fp_out <= fp_add(fp_t'(vcount_fp_out), Y_STEP);
            end else begin
              state_q        <= S_IDLE;
              valid_out      <= 1'b0;
              busy_out       <= 1'b0;
              frame_done_out <= 1'b1;
`ifdef RAY_SCHED_INTERLACE_EN
              field_odd      <= ~field_odd;
`endif
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// tb_ray_pixel_scheduler
//   Directed bench for ray_pixel_scheduler. Default build: W=4, H=2
//   (step 1.0, x0=-2.0, y0=-1.0). With RAY_SCHED_INTERLACE_EN: W=4, H=4
//   (step 0.5, x0=-1.0) and two alternating-field frames.

module tb_ray_pixel_scheduler;

  localparam int W = 4;
`ifdef RAY_SCHED_INTERLACE_EN
  localparam int H = 4;
`else
  localparam int H = 2;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic        ready_in = 1'b0;
  logic        valid_out;
  logic [3:0]  hcount_out;
  logic [3:0]  vcount_out;
  logic [15:0] hcount_fp_out;
  logic [15:0] vcount_fp_out;
  logic        busy_out;
  logic        frame_done_out;

  int nvec = 0;
  int nerr = 0;

  ray_pixel_scheduler #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .H_BITS        (4),
    .V_BITS        (4)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .hcount_fp_out (hcount_fp_out),
    .vcount_fp_out (vcount_fp_out),
    .busy_out      (busy_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Q3.12 encoding of a real value (only exact values are used).
  function automatic logic [15:0] fpv(input real r);
    int i;
    i = $rtoi(r * 4096.0);
    return i[15:0];
  endfunction

  task automatic pix(input string tag, input int h, input int v, input real x, input real y);
    chk({tag, ".valid"}, 32'(valid_out), 32'd1);
    chk({tag, ".busy"},  32'(busy_out),  32'd1);
    chk({tag, ".h"},     32'(hcount_out), 32'(h));
    chk({tag, ".v"},     32'(vcount_out), 32'(v));
    chk({tag, ".x"},     32'(hcount_fp_out), 32'(fpv(x)));
    chk({tag, ".y"},     32'(vcount_fp_out), 32'(fpv(y)));
  endtask

  // Pulse start for one cycle; returns at the negedge where pixel 0 shows.
  task automatic start_pulse();
    @(negedge clk_in) start_in = 1'b1;
    @(negedge clk_in) start_in = 1'b0;
  endtask

  // Full frame with ready held high: rows v0, v0+vstep, ... (nrows of them).
  task automatic run_frame(input string tag, input int v0, input int vstep, input int nrows);
    real step;
    step = 2.0 / H;
    start_pulse();
    for (int r = 0; r < nrows; r++) begin
      for (int h = 0; h < W; h++) begin
        pix(tag, h, v0 + r * vstep, -1.0 * W / H + h * step, -1.0 + (v0 + r * vstep) * step);
        @(negedge clk_in);
      end
    end
    chk({tag, ".done"},      32'(frame_done_out), 32'd1);
    chk({tag, ".end_valid"}, 32'(valid_out),      32'd0);
    chk({tag, ".end_busy"},  32'(busy_out),       32'd0);
    @(negedge clk_in);
    chk({tag, ".done_1cyc"}, 32'(frame_done_out), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done_out && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, ".done_seen"}, 32'(frame_done_out), 32'd1);
    @(negedge clk_in);
  endtask

  initial begin
    int xfers;
    int dones;
    // Reset state
    #3;
    chk("rst.valid", 32'(valid_out), 32'd0);
    chk("rst.busy",  32'(busy_out),  32'd0);
    chk("rst.done",  32'(frame_done_out), 32'd0);
    chk("rst.h",     32'(hcount_out), 32'd0);
    chk("rst.x",     32'(hcount_fp_out), 32'd0);
    chk("rst.y",     32'(vcount_fp_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    ready_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("idle.valid", 32'(valid_out), 32'd0);

`ifdef RAY_SCHED_INTERLACE_EN
    // Frame 1: even rows (y=-1.0, 0.0); frame 2: odd rows (y=-0.5, 0.5).
    run_frame("il_f1", 0, 2, 2);
    run_frame("il_f2", 1, 2, 2);
    run_frame("il_f3", 0, 2, 2);
`else
    // Full frame, one pixel per cycle.
    run_frame("frame", 0, 1, 2);

    // Backpressure at (2,0).
    start_pulse();
    pix("st0", 0, 0, -2.0, -1.0);
    @(negedge clk_in);
    pix("st1", 1, 0, -1.0, -1.0);
    @(negedge clk_in);
    pix("st2", 2, 0, 0.0, -1.0);
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      pix("stall", 2, 0, 0.0, -1.0);
    end
    ready_in = 1'b1;
    @(negedge clk_in);
    pix("resume", 3, 0, 1.0, -1.0);
    wait_done("stall_frame");

    // Asynchronous reset at (1,1).
    start_pulse();
    repeat (5) @(negedge clk_in);
    pix("pre_rst", 1, 1, -1.0, 0.0);
    #1 rst_n_in = 1'b0;
    #1;
    chk("arst.valid", 32'(valid_out), 32'd0);
    chk("arst.busy",  32'(busy_out),  32'd0);
    chk("arst.h",     32'(hcount_out), 32'd0);
    chk("arst.v",     32'(vcount_out), 32'd0);
    #1 rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("post_rst.valid", 32'(valid_out), 32'd0);
    end
    start_pulse();
    pix("restart", 0, 0, -2.0, -1.0);
    wait_done("restart_frame");

    // start held high: no restart mid-frame, back-to-back second frame.
    xfers = 0;
    dones = 0;
    @(negedge clk_in) start_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (frame_done_out) begin
        dones++;
        if (dones == 1) begin
          @(negedge clk_in);
          start_in = 1'b0;
          pix("b2b_first", 0, 0, -2.0, -1.0);
          xfers++;  // this pixel transfers at the next edge
        end
      end else if (valid_out && ready_in) begin
        xfers++;
      end
    end
    start_in = 1'b0;
    chk("b2b.xfers", 32'(xfers), 32'd16);
    chk("b2b.dones", 32'(dones), 32'd2);
    chk("b2b.idle",  32'(valid_out), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
